// File: rtl/rs232_mem_pkg.sv
// Shared constants, state encoding and helpers for the RS-232 memory master.
package rs232_mem_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CMD_READ  = 8'h52;
  localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h57;
  localparam logic [BYTE_W-1:0] RPL_OK    = 8'h4B;
  localparam logic [BYTE_W-1:0] RPL_ERR   = 8'h45;

  typedef enum logic [2:0] {
    IDLE,
    GET_PAGE,
    GET_OFFSET,
    GET_DATA,
    GET_MASK,
    ISSUE,
    WAIT_ACK,
    SEND
  } state_t;

  // Saturating increment for the 8-bit error counter.
  function automatic logic [BYTE_W-1:0] sat_inc(input logic [BYTE_W-1:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rs232_mem_master_if.sv
// Memory request bus driven by the RS-232 command master.
interface rs232_mem_master_if;
  import rs232_mem_pkg::*;

  logic [BYTE_W-1:0] rs232_mem_page;
  logic [BYTE_W-1:0] rs232_mem_offset;
  logic [BYTE_W-1:0] rs232_mem_wr_data;
  logic [BYTE_W-1:0] rs232_mem_wr_msk;
  logic              rs232_mem_wr_en;
  logic              rs232_mem_rd_en;
  logic [BYTE_W-1:0] rs232_mem_rd_data;
  logic              rs232_mem_ack;

  modport master (
    output rs232_mem_page, rs232_mem_offset, rs232_mem_wr_data, rs232_mem_wr_msk,
    output rs232_mem_wr_en, rs232_mem_rd_en,
    input  rs232_mem_rd_data, rs232_mem_ack
  );

  modport slave (
    input  rs232_mem_page, rs232_mem_offset, rs232_mem_wr_data, rs232_mem_wr_msk,
    input  rs232_mem_wr_en, rs232_mem_rd_en,
    output rs232_mem_rd_data, rs232_mem_ack
  );

endinterface

// File: rtl/rs232_mem_master.sv
// Parses UART read/write frames, issues one memory request per frame and
// returns a single reply byte (read data, ack code or timeout code).
module rs232_mem_master
  import rs232_mem_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT  = 255,
  parameter int unsigned BYTE_TIMEOUT = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BYTE_W-1:0]     rx_data,
  input  logic                  rx_valid,
  output logic [BYTE_W-1:0]     tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  rs232_mem_master_if.master    mem,
  output logic                  busy,
  output logic [BYTE_W-1:0]     err_count
);

  localparam int unsigned ACK_TW  = 16;
  localparam int unsigned BYTE_TW = 24;

  state_t               state, state_nx;
  logic                 is_write, is_write_nx;
  logic [ACK_TW-1:0]    ack_timer, ack_timer_nx;
  logic [BYTE_TW-1:0]   byte_timer, byte_timer_nx;
  logic [BYTE_W-1:0]    page_nx, offset_nx, wr_data_nx, wr_msk_nx, tx_data_nx, err_count_nx;
  logic                 tx_valid_nx, wr_en_nx, rd_en_nx, busy_nx;
  logic                 err_event;

  logic rx_is_cmd, byte_expired, ack_expired, tx_done;
  assign rx_is_cmd    = (rx_data == CMD_READ) || (rx_data == CMD_WRITE);
  assign byte_expired = (byte_timer <= BYTE_TW'(1));
  assign ack_expired  = (ack_timer <= ACK_TW'(1));
  assign tx_done      = tx_valid && tx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (rx_valid && rx_is_cmd) state_nx = GET_PAGE;
      GET_PAGE:   if (rx_valid) state_nx = GET_OFFSET;
                  else if (byte_expired) state_nx = IDLE;
      GET_OFFSET: if (rx_valid) state_nx = is_write ? GET_DATA : ISSUE;
                  else if (byte_expired) state_nx = IDLE;
      GET_DATA:   if (rx_valid) state_nx = GET_MASK;
                  else if (byte_expired) state_nx = IDLE;
      GET_MASK:   if (rx_valid) state_nx = ISSUE;
                  else if (byte_expired) state_nx = IDLE;
      ISSUE:      state_nx = WAIT_ACK;
      WAIT_ACK:   if (mem.rs232_mem_ack || ack_expired) state_nx = SEND;
      SEND:       if (tx_done) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  // Next values of every registered output, timer and frame field.
  always_comb begin
    is_write_nx   = is_write;
    byte_timer_nx = byte_timer;
    ack_timer_nx  = ack_timer;
    page_nx       = mem.rs232_mem_page;
    offset_nx     = mem.rs232_mem_offset;
    wr_data_nx    = mem.rs232_mem_wr_data;
    wr_msk_nx     = mem.rs232_mem_wr_msk;
    tx_data_nx    = tx_data;
    tx_valid_nx   = 1'b0;
    wr_en_nx      = (state_nx == ISSUE) && is_write;
    rd_en_nx      = (state_nx == ISSUE) && !is_write;
    busy_nx       = (state_nx != IDLE);
    err_event     = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_is_cmd) begin
            is_write_nx   = (rx_data == CMD_WRITE);
            byte_timer_nx = BYTE_TW'(BYTE_TIMEOUT);
          end else begin
            err_event = 1'b1;
          end
        end
      end
      GET_PAGE, GET_OFFSET, GET_DATA, GET_MASK: begin
        if (rx_valid) begin
          byte_timer_nx = BYTE_TW'(BYTE_TIMEOUT);
          case (state)
            GET_PAGE:   page_nx    = rx_data;
            GET_OFFSET: offset_nx  = rx_data;
            GET_DATA:   wr_data_nx = rx_data;
            default:    wr_msk_nx  = rx_data;
          endcase
        end else if (byte_expired) begin
          byte_timer_nx = '0;
          err_event     = 1'b1;
        end else begin
          byte_timer_nx = byte_timer - BYTE_TW'(1);
        end
      end
      ISSUE: begin
        ack_timer_nx = ACK_TW'(ACK_TIMEOUT);
        err_event    = rx_valid;
      end
      WAIT_ACK: begin
        err_event = rx_valid;
        if (mem.rs232_mem_ack) begin
          ack_timer_nx = '0;
          tx_data_nx   = is_write ? RPL_OK : mem.rs232_mem_rd_data;
        end else if (ack_expired) begin
          ack_timer_nx = '0;
          tx_data_nx   = RPL_ERR;
          err_event    = 1'b1;
        end else begin
          ack_timer_nx = ack_timer - ACK_TW'(1);
        end
      end
      SEND: begin
        err_event   = rx_valid;
        // First SEND cycle only loads tx_valid, giving a two-cycle ack-to-valid latency.
        tx_valid_nx = !tx_done;
      end
      default: ;
    endcase
    err_count_nx = err_event ? sat_inc(err_count) : err_count;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_write              <= 1'b0;
      byte_timer            <= '0;
      ack_timer             <= '0;
      mem.rs232_mem_page    <= '0;
      mem.rs232_mem_offset  <= '0;
      mem.rs232_mem_wr_data <= '0;
      mem.rs232_mem_wr_msk  <= '0;
      mem.rs232_mem_wr_en   <= 1'b0;
      mem.rs232_mem_rd_en   <= 1'b0;
      tx_data               <= '0;
      tx_valid              <= 1'b0;
      busy                  <= 1'b0;
      err_count             <= '0;
    end else begin
      is_write              <= is_write_nx;
      byte_timer            <= byte_timer_nx;
      ack_timer             <= ack_timer_nx;
      mem.rs232_mem_page    <= page_nx;
      mem.rs232_mem_offset  <= offset_nx;
      mem.rs232_mem_wr_data <= wr_data_nx;
      mem.rs232_mem_wr_msk  <= wr_msk_nx;
      mem.rs232_mem_wr_en   <= wr_en_nx;
      mem.rs232_mem_rd_en   <= rd_en_nx;
      tx_data               <= tx_data_nx;
      tx_valid              <= tx_valid_nx;
      busy                  <= busy_nx;
      err_count             <= err_count_nx;
    end
  end

endmodule
